stopwatch_core: RTL and testbench
=================================

Name: stopwatch_core

Overview:
- Parametrised successor to the lab stopwatch counter; a single-clock-domain MM:SS timekeeping core.
- All 1 Hz and adjust-rate timing comes from internal clock-enable ticks. No derived or gated clocks.
- Adds count-down mode with expiry, lap capture and an adjust-blink output for the display.
- Sits between the board input conditioning (debounced buttons/switches) and the seven-segment driver.

Parameters:
- CLK_HZ, 100000000, system clock frequency; must be a multiple of ADJ_HZ.
- ADJ_HZ, 2, adjust-mode increment rate in Hz; must be ≥1.
- MAX_MIN, 59, highest minutes value; MW = $clog2(MAX_MIN+1).
- WRAP, 1, up-count at MAX_MIN:59: 1 = wrap to 00:00, 0 = saturate.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear, active high.
- pause  in  1  level; 1 freezes counting and adjusting.
- adj  in  1  level; 1 = adjust mode.
- sel  in  1  adjust field: 0 = minutes, 1 = seconds.
- dir  in  1  0 = count up, 1 = count down.
- lap  in  1  level, debounced; rising edge captures a lap.
- mins  out  MW  current minutes.
- secs  out  6  current seconds.
- lap_mins  out  MW  captured minutes.
- lap_secs  out  6  captured seconds.
- lap_valid  out  1  sticky; set on the first capture.
- expired  out  1  sticky; down-count reached 00:00.
- blink  out  1  flash phase for the selected field.
- tick_1hz  out  1  one-cycle 1 Hz strobe.

Behaviour:
- Reset (reset_n=0, async):
  - mins, secs, lap_mins, lap_secs = 0.
  - lap_valid, expired, blink, tick_1hz = 0.
  - Prescaler and lap edge register = 0.
- Priority per cycle: clr > adjust > normal count.
  - clr: same outputs as reset except the lap edge register, which keeps tracking lap; also zeroes the prescaler.
- Prescaler:
  - div counts 0..CLK_HZ/ADJ_HZ-1, then wraps.
  - tick_adj is high for the one cycle where div is at its terminal value.
  - tick_1hz is high on every ADJ_HZ-th tick_adj; a second counter, sub, counts 0..ADJ_HZ-1.
  - Free-running; ignores pause and adj.
  - First tick_1hz occurs CLK_HZ cycles after reset/clr release.
- Update timing: state changes on the clock edge that ends a tick cycle; new values are visible the next cycle.
- Normal mode (adj=0, pause=0), on tick_1hz:
  - dir=0: secs 59→0 with mins+1. At MAX_MIN:59: WRAP=1 gives 00:00; WRAP=0 holds.
  - dir=1: secs 0→59 with mins-1. From 00:01 → 00:00 sets expired.
  - At 00:00 with dir=1: hold and set expired.
  - While expired=1, down-counting is frozen.
  - dir=0 resumes counting and leaves expired unchanged.
- Adjust mode (adj=1, pause=0), on tick_adj:
  - sel=0: mins+1, MAX_MIN→0.
  - sel=1: secs+1, 59→0, no carry into mins.
  - Any adjust increment clears expired.
  - tick_1hz is ignored for counting.
- pause=1: mins/secs frozen in both modes; prescaler keeps running.
- blink: toggles on each tick_adj while adj=1; forced to 0 the cycle after adj=0.
- Lap capture:
  - lap_q registers lap; rise = lap & ~lap_q.
  - On rise: lap_mins/lap_secs take the current (pre-update) mins/secs, and lap_valid is set.
  - Capture works in every mode, including pause.
  - Lap rise and tick in the same cycle: captures the old value.
- Mode switch mid-count: takes effect at the next tick; the prescaler is not reset.

Decomposition:
- Package stopwatch_pkg holds:
  - SEC_MAX = 59.
  - Function next_field(value, max, up) returning the wrapped value and a carry/borrow.
- One natural sub-module, tick_gen (prescaler): parameters CLK_HZ and ADJ_HZ; outputs tick_adj and tick_1hz.

Test Plan:
(CLK_HZ=4, ADJ_HZ=2, MAX_MIN=59 unless stated)
- Reset and up-count:
  - Stimulus: release reset_n, dir=0.
  - Response: tick_1hz every 4 cycles; after 60 ticks, mins=1 and secs=0; after 3600 ticks, 00:00 (WRAP=1).
- Saturate:
  - Stimulus: WRAP=0, preset 59:58 via adjust.
  - Response: after 3 tick_1hz, held at 59:59.
- Down-count and expiry:
  - Stimulus: adjust to 00:02, then adj=0, dir=1.
  - Response: 00:01, then 00:00 with expired=1; further ticks hold 00:00.
  - Then adj=1, sel=1: the first tick_adj gives secs=1 and expired=0.
- Adjust and pause:
  - Stimulus: adj=1, sel=0 for 8 cycles.
  - Response: mins +4, blink toggling every 2 cycles.
  - Then pause=1 for 20 cycles: no change.
  - Then sel=1, pause=0 from secs=59: secs→0 and mins unchanged.
- Lap coincident with tick:
  - Stimulus: lap rises in the same cycle as the tick_1hz taking 00:07→00:08.
  - Response: lap=00:07 and lap_valid=1; holding lap high gives no further capture.
- Async reset and clr mid-count:
  - Stimulus: reset_n low mid-cycle at 03:21.
  - Response: all outputs 0 immediately.
  - Stimulus: clr at 05:10 with lap_valid=1.
  - Response: 00:00, lap_valid=0, next tick_1hz 4 cycles after clr.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared constants, types and field-stepping helper for the stopwatch core.
package stopwatch_pkg;

    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned FIELD_W = 16;

    typedef logic [FIELD_W-1:0] field_t;

    typedef struct packed {
        field_t value;
        logic   carry;   // carry on up-wrap, borrow on down-wrap
    } field_step_t;

    typedef enum logic [1:0] {
        MODE_CLEAR,
        MODE_HOLD,
        MODE_ADJUST,
        MODE_COUNT
    } mode_e;

    // Step a time field by one in either direction, wrapping between 0 and max.
    function automatic field_step_t next_field(input field_t value, input field_t max,
                                               input logic up);
        field_step_t r;
        r.value = value;
        r.carry = 1'b0;
        if (up) begin
            if (value >= max) begin
                r.value = '0;
                r.carry = 1'b1;
            end else begin
                r.value = value + field_t'(1);
            end
        end else begin
            if (value == '0) begin
                r.value = max;
                r.carry = 1'b1;
            end else begin
                r.value = value - field_t'(1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_core_tick_gen.sv
// Free-running prescaler producing adjust-rate and 1 Hz clock-enable strobes.
module tick_gen #(
    parameter int unsigned CLK_HZ = 100000000,
    parameter int unsigned ADJ_HZ = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    output logic tick_adj,
    output logic tick_1hz
);

    localparam int unsigned DIV_N = CLK_HZ / ADJ_HZ;
    localparam int unsigned DIV_W = (DIV_N > 1) ? $clog2(DIV_N) : 1;
    localparam int unsigned SUB_W = (ADJ_HZ > 1) ? $clog2(ADJ_HZ) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_N - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(ADJ_HZ - 1);

    logic [DIV_W-1:0] div;
    logic [SUB_W-1:0] sub;
    logic             div_end;

    assign div_end = (div == DIV_LAST);

    // Divider chain: div counts clock cycles, sub counts adjust ticks within a second.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div <= '0;
            sub <= '0;
        end else if (clr) begin
            div <= '0;
            sub <= '0;
        end else if (div_end) begin
            div <= '0;
            sub <= (sub == SUB_LAST) ? '0 : sub + SUB_W'(1);
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    assign tick_adj = div_end & ~clr;
    assign tick_1hz = div_end & (sub == SUB_LAST) & ~clr;

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch with count up/down, expiry, adjust mode and lap capture.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter  int unsigned CLK_HZ  = 100000000,
    parameter  int unsigned ADJ_HZ  = 2,
    parameter  int unsigned MAX_MIN = 59,
    parameter  int unsigned WRAP    = 1,
    localparam int unsigned MW      = $clog2(MAX_MIN + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr,
    input  logic          pause,
    input  logic          adj,
    input  logic          sel,
    input  logic          dir,
    input  logic          lap,
    output logic [MW-1:0] mins,
    output logic [5:0]    secs,
    output logic [MW-1:0] lap_mins,
    output logic [5:0]    lap_secs,
    output logic          lap_valid,
    output logic          expired,
    output logic          blink,
    output logic          tick_1hz
);

    logic          tick_adj;
    logic          lap_q;
    logic          lap_rise;
    mode_e         mode;
    field_step_t   sec_up, sec_dn, min_up, min_dn;
    logic [MW-1:0] mins_nxt;
    logic [5:0]    secs_nxt;
    logic          expired_nxt;
    logic          unused_field_bits;

    tick_gen #(
        .CLK_HZ(CLK_HZ),
        .ADJ_HZ(ADJ_HZ)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .tick_adj(tick_adj),
        .tick_1hz(tick_1hz)
    );

    assign lap_rise = lap & ~lap_q;

    // Field steps never exceed MAX_MIN / SEC_MAX, so the upper bits stay zero.
    assign unused_field_bits = ^{sec_up.value[FIELD_W-1:6], sec_dn.value[FIELD_W-1:6],
                                 min_up.value[FIELD_W-1:MW], min_dn.value[FIELD_W-1:MW],
                                 sec_dn.carry, min_dn.carry};

    // Operating mode in priority order: clear, pause, adjust, count.
    always_comb begin
        mode = MODE_COUNT;
        if (clr)        mode = MODE_CLEAR;
        else if (pause) mode = MODE_HOLD;
        else if (adj)   mode = MODE_ADJUST;
    end

    // Next time/expiry state for the current mode and tick strobes.
    always_comb begin
        mins_nxt    = mins;
        secs_nxt    = secs;
        expired_nxt = expired;
        sec_up      = next_field(field_t'(secs), field_t'(SEC_MAX), 1'b1);
        sec_dn      = next_field(field_t'(secs), field_t'(SEC_MAX), 1'b0);
        min_up      = next_field(field_t'(mins), field_t'(MAX_MIN), 1'b1);
        min_dn      = next_field(field_t'(mins), field_t'(MAX_MIN), 1'b0);
        case (mode)
            MODE_CLEAR: begin
                mins_nxt    = '0;
                secs_nxt    = '0;
                expired_nxt = 1'b0;
            end
            MODE_ADJUST: begin
                if (tick_adj) begin
                    expired_nxt = 1'b0;
                    if (sel) secs_nxt = sec_up.value[5:0];
                    else     mins_nxt = min_up.value[MW-1:0];
                end
            end
            MODE_COUNT: begin
                if (tick_1hz) begin
                    if (!dir) begin
                        if (!sec_up.carry) begin
                            secs_nxt = sec_up.value[5:0];
                        end else if (!min_up.carry) begin
                            secs_nxt = '0;
                            mins_nxt = min_up.value[MW-1:0];
                        end else if (WRAP != 0) begin
                            secs_nxt = '0;
                            mins_nxt = '0;
                        end
                    end else if (!expired) begin
                        if (mins == '0 && secs == '0) begin
                            expired_nxt = 1'b1;
                        end else begin
                            secs_nxt = sec_dn.value[5:0];
                            if (sec_up.value[5:0] == '0 && secs == '0) mins_nxt = mins;
                            if (secs == '0) mins_nxt = min_dn.value[MW-1:0];
                            if (mins == '0 && secs == 6'd1) expired_nxt = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Time and expiry registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mins    <= '0;
            secs    <= '0;
            expired <= 1'b0;
        end else begin
            mins    <= mins_nxt;
            secs    <= secs_nxt;
            expired <= expired_nxt;
        end
    end

    // Lap capture on the rising edge of lap; the edge register keeps tracking through clr.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lap_q     <= 1'b0;
            lap_mins  <= '0;
            lap_secs  <= '0;
            lap_valid <= 1'b0;
        end else begin
            lap_q <= lap;
            if (clr) begin
                lap_mins  <= '0;
                lap_secs  <= '0;
                lap_valid <= 1'b0;
            end else if (lap_rise) begin
                lap_mins  <= mins;
                lap_secs  <= secs;
                lap_valid <= 1'b1;
            end
        end
    end

    // Adjust-mode flash phase, parked low outside adjust mode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          blink <= 1'b0;
        else if (clr || !adj)  blink <= 1'b0;
        else if (tick_adj)     blink <= ~blink;
    end

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed testbench for stopwatch_core with CLK_HZ=4, ADJ_HZ=2.
module tb_stopwatch_core;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clr = 1'b0, pause = 1'b0, adj = 1'b0, sel = 1'b0, dir = 1'b0, lap = 1'b0;
    logic [5:0] mins, secs, lap_mins, lap_secs;
    logic       lap_valid, expired, blink, tick_1hz;
    logic [5:0] s_mins, s_secs, s_lap_mins, s_lap_secs;
    logic       s_lap_valid, s_expired, s_blink, s_tick_1hz;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    stopwatch_core #(.CLK_HZ(4), .ADJ_HZ(2), .MAX_MIN(59), .WRAP(1)) dut (
        .clk(clk), .reset_n(reset_n), .clr(clr), .pause(pause), .adj(adj), .sel(sel),
        .dir(dir), .lap(lap), .mins(mins), .secs(secs), .lap_mins(lap_mins),
        .lap_secs(lap_secs), .lap_valid(lap_valid), .expired(expired), .blink(blink),
        .tick_1hz(tick_1hz)
    );

    stopwatch_core #(.CLK_HZ(4), .ADJ_HZ(2), .MAX_MIN(59), .WRAP(0)) dut_sat (
        .clk(clk), .reset_n(reset_n), .clr(clr), .pause(pause), .adj(adj), .sel(sel),
        .dir(dir), .lap(lap), .mins(s_mins), .secs(s_secs), .lap_mins(s_lap_mins),
        .lap_secs(s_lap_secs), .lap_valid(s_lap_valid), .expired(s_expired),
        .blink(s_blink), .tick_1hz(s_tick_1hz)
    );

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_ticks(input int n);
        int seen  = 0;
        int guard = 0;
        while (seen < n && guard < 8 * n + 8) begin
            if (tick_1hz === 1'b1) seen++;
            step();
            guard++;
        end
        if (seen < n) begin
            errs++;
            $display("FAIL tick_timeout: saw %0d tick_1hz, wanted %0d", seen, n);
        end
    endtask

    // Synchronous clear; returns in the first cycle after clr (prescaler at zero).
    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        int cnt = 0;
        step(2);
        vecs++;
        if ({mins, secs, lap_mins, lap_secs, lap_valid, expired, blink, tick_1hz} !== '0) begin
            errs++;
            $display("FAIL reset_state: got %0d:%0d lap %0d:%0d v%b e%b b%b t%b, want all 0",
                     mins, secs, lap_mins, lap_secs, lap_valid, expired, blink, tick_1hz);
        end
        reset_n = 1'b1;
        while (tick_1hz !== 1'b1 && cnt < 10) begin
            step();
            cnt++;
        end
        vecs++;
        if (cnt != 3) begin
            errs++;
            $display("FAIL first_tick: got tick after %0d cycles, want 3", cnt);
        end
    endtask

    task automatic test_up_count();
        dir = 1'b0;
        run_ticks(60);
        vecs++;
        if ({mins, secs} !== {6'd1, 6'd0}) begin
            errs++;
            $display("FAIL up_60: got %0d:%0d want 1:0", mins, secs);
        end
        for (int k = 1; k <= 3; k++) begin
            step();
            vecs++;
            if (tick_1hz !== (k == 3)) begin
                errs++;
                $display("FAIL tick_period_%0d: got %b want %b", k, tick_1hz, k == 3);
            end
        end
        run_ticks(3540);
        vecs++;
        if ({mins, secs} !== {6'd0, 6'd0}) begin
            errs++;
            $display("FAIL up_3600_wrap: got %0d:%0d want 0:0", mins, secs);
        end
        vecs++;
        if ({s_mins, s_secs} !== {6'd59, 6'd59}) begin
            errs++;
            $display("FAIL up_3600_sat: got %0d:%0d want 59:59", s_mins, s_secs);
        end
    endtask

    task automatic test_saturate();
        do_clr();
        dir = 1'b0; adj = 1'b1; sel = 1'b0;
        step(118);
        sel = 1'b1;
        step(116);
        adj = 1'b0;
        vecs++;
        if ({s_mins, s_secs} !== {6'd59, 6'd58}) begin
            errs++;
            $display("FAIL sat_preset: got %0d:%0d want 59:58", s_mins, s_secs);
        end
        run_ticks(3);
        vecs++;
        if ({s_mins, s_secs} !== {6'd59, 6'd59}) begin
            errs++;
            $display("FAIL sat_hold: got %0d:%0d want 59:59", s_mins, s_secs);
        end
        vecs++;
        if ({mins, secs} !== {6'd0, 6'd1}) begin
            errs++;
            $display("FAIL wrap_after_59_59: got %0d:%0d want 0:1", mins, secs);
        end
    endtask

    task automatic test_down_expiry();
        do_clr();
        adj = 1'b1; sel = 1'b1;
        step(4);
        adj = 1'b0; dir = 1'b1;
        run_ticks(1);
        vecs++;
        if ({mins, secs, expired} !== {6'd0, 6'd1, 1'b0}) begin
            errs++;
            $display("FAIL down_0_01: got %0d:%0d e%b want 0:1 e0", mins, secs, expired);
        end
        run_ticks(1);
        vecs++;
        if ({mins, secs, expired} !== {6'd0, 6'd0, 1'b1}) begin
            errs++;
            $display("FAIL down_expire: got %0d:%0d e%b want 0:0 e1", mins, secs, expired);
        end
        run_ticks(2);
        vecs++;
        if ({mins, secs, expired} !== {6'd0, 6'd0, 1'b1}) begin
            errs++;
            $display("FAIL down_hold: got %0d:%0d e%b want 0:0 e1", mins, secs, expired);
        end
        adj = 1'b1; sel = 1'b1;
        step(2);
        vecs++;
        if ({mins, secs, expired, blink} !== {6'd0, 6'd1, 1'b0, 1'b1}) begin
            errs++;
            $display("FAIL adj_clears_expired: got %0d:%0d e%b b%b want 0:1 e0 b1",
                     mins, secs, expired, blink);
        end
        adj = 1'b0;
        step();
        vecs++;
        if (blink !== 1'b0) begin
            errs++;
            $display("FAIL blink_off: got %b want 0", blink);
        end
    endtask

    task automatic test_adjust_pause();
        do_clr();
        dir = 1'b0; adj = 1'b1; sel = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            vecs++;
            if (blink !== 1'(((k / 2) % 2))) begin
                errs++;
                $display("FAIL blink_cycle_%0d: got %b want %0d", k, blink, (k / 2) % 2);
            end
        end
        vecs++;
        if ({mins, secs} !== {6'd4, 6'd0}) begin
            errs++;
            $display("FAIL adj_mins: got %0d:%0d want 4:0", mins, secs);
        end
        pause = 1'b1;
        step(20);
        vecs++;
        if ({mins, secs} !== {6'd4, 6'd0}) begin
            errs++;
            $display("FAIL pause_hold: got %0d:%0d want 4:0", mins, secs);
        end
        pause = 1'b0; sel = 1'b1;
        step(118);
        vecs++;
        if ({mins, secs} !== {6'd4, 6'd59}) begin
            errs++;
            $display("FAIL adj_secs_59: got %0d:%0d want 4:59", mins, secs);
        end
        step(2);
        vecs++;
        if ({mins, secs} !== {6'd4, 6'd0}) begin
            errs++;
            $display("FAIL adj_secs_wrap: got %0d:%0d want 4:0", mins, secs);
        end
        adj = 1'b0;
    endtask

    task automatic test_lap_tick();
        do_clr();
        dir = 1'b0; adj = 1'b0; pause = 1'b0; lap = 1'b0;
        vecs++;
        if ({lap_valid, lap_mins, lap_secs} !== '0) begin
            errs++;
            $display("FAIL lap_after_clr: got v%b %0d:%0d want v0 0:0", lap_valid, lap_mins, lap_secs);
        end
        run_ticks(7);
        step(3);
        vecs++;
        if ({tick_1hz, mins, secs} !== {1'b1, 6'd0, 6'd7}) begin
            errs++;
            $display("FAIL lap_pre: got t%b %0d:%0d want t1 0:7", tick_1hz, mins, secs);
        end
        lap = 1'b1;
        step();
        vecs++;
        if ({mins, secs, lap_mins, lap_secs, lap_valid} !== {6'd0, 6'd8, 6'd0, 6'd7, 1'b1}) begin
            errs++;
            $display("FAIL lap_coincident: got %0d:%0d lap %0d:%0d v%b want 0:8 lap 0:7 v1",
                     mins, secs, lap_mins, lap_secs, lap_valid);
        end
        run_ticks(2);
        vecs++;
        if ({mins, secs, lap_mins, lap_secs} !== {6'd0, 6'd10, 6'd0, 6'd7}) begin
            errs++;
            $display("FAIL lap_held: got %0d:%0d lap %0d:%0d want 0:10 lap 0:7",
                     mins, secs, lap_mins, lap_secs);
        end
        lap = 1'b0;
    endtask

    task automatic test_async_reset();
        do_clr();
        dir = 1'b0; adj = 1'b1; sel = 1'b0;
        step(6);
        sel = 1'b1;
        step(42);
        adj = 1'b0; lap = 1'b1;
        step();
        lap = 1'b0;
        vecs++;
        if ({mins, secs, lap_valid} !== {6'd3, 6'd21, 1'b1}) begin
            errs++;
            $display("FAIL pre_reset: got %0d:%0d v%b want 3:21 v1", mins, secs, lap_valid);
        end
        #3 reset_n = 1'b0;
        #1;
        vecs++;
        if ({mins, secs, lap_mins, lap_secs, lap_valid, expired, blink, tick_1hz} !== '0) begin
            errs++;
            $display("FAIL async_reset: got %0d:%0d lap %0d:%0d v%b e%b b%b t%b want all 0",
                     mins, secs, lap_mins, lap_secs, lap_valid, expired, blink, tick_1hz);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_clr();
        dir = 1'b0; adj = 1'b1; sel = 1'b0;
        step(10);
        sel = 1'b1;
        step(20);
        adj = 1'b0; lap = 1'b1;
        step();
        vecs++;
        if ({mins, secs, lap_mins, lap_secs, lap_valid, tick_1hz} !==
            {6'd5, 6'd10, 6'd5, 6'd10, 1'b1, 1'b1}) begin
            errs++;
            $display("FAIL pre_clr: got %0d:%0d lap %0d:%0d v%b t%b want 5:10 lap 5:10 v1 t1",
                     mins, secs, lap_mins, lap_secs, lap_valid, tick_1hz);
        end
        clr = 1'b1; lap = 1'b0;
        step();
        clr = 1'b0;
        vecs++;
        if ({mins, secs, lap_mins, lap_secs, lap_valid, expired} !== '0) begin
            errs++;
            $display("FAIL clr_state: got %0d:%0d lap %0d:%0d v%b e%b want all 0",
                     mins, secs, lap_mins, lap_secs, lap_valid, expired);
        end
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) step();
            vecs++;
            if (tick_1hz !== (k == 3)) begin
                errs++;
                $display("FAIL clr_tick_%0d: got %b want %b", k, tick_1hz, k == 3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_saturate();
        test_down_expiry();
        test_adjust_pause();
        test_lap_tick();
        test_async_reset();
        test_clr();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
